// File: rtl/des_pkg.sv
// Shared definitions for the DES key schedule: FSM states, per-round
// rotation amounts, PC-2 selection table and 28-bit rotate helpers.
package des_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Left-rotation amount applied to C and D before round r (encrypt order)
    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // PC-2: subkey bit j+1 (DES numbering) takes bit PC2_IDX[j] of C||D
    localparam int PC2_IDX [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // DES bit 1 is the MSB, so "left" moves bits toward the MSB
    function automatic logic [27:0] rol28(input logic [27:0] v, input logic [1:0] n);
        case (n)
            2'd1:    return {v[26:0], v[27]};
            2'd2:    return {v[25:0], v[27:26]};
            default: return v;
        endcase
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] v, input logic [1:0] n);
        case (n)
            2'd1:    return {v[0], v[27:1]};
            2'd2:    return {v[1:0], v[27:2]};
            default: return v;
        endcase
    endfunction

endpackage

// File: rtl/des_key_permutation1.sv
// PC-1: drops the parity bits of a 64-bit DES key and splits the rest
// into C (cd[55:28]) and D (cd[27:0]). Bit numbering is DES order, MSB first.
module des_key_permutation1 (
    input  logic [63:0] key,
    output logic [55:0] cd
);

    localparam int PC1_IDX [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // Pure bit selection
    always_comb begin
        cd = '0;
        for (int j = 0; j < 56; j++) begin
            cd[55-j] = key[64-PC1_IDX[j]];
        end
    end

endmodule

// File: rtl/des_key_permutation2.sv
// PC-2: compresses the 56-bit C||D register into a 48-bit round subkey.
module des_key_permutation2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subkey
);

    // Pure bit selection
    always_comb begin
        subkey = '0;
        for (int j = 0; j < 48; j++) begin
            subkey[47-j] = cd[56-PC2_IDX[j]];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule. Accepts NUM_KEYS keys (1 = DES, 3 = 3DES)
// in one handshake and streams 16 round subkeys per key, each key in its
// own encrypt or decrypt order. C/D are held pre-rotated so the subkey is
// simply PC-2 of the registers.
// Optional feature: define KEY_PARITY_CHECK_EN to add the per-byte odd
// parity flags (parity_err).
module des_key_schedule
    import des_pkg::*;
#(
    parameter int NUM_KEYS = 3   // only 1 or 3 are meaningful
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [64*NUM_KEYS-1:0]   key_in,
    input  logic [NUM_KEYS-1:0]      key_mode,
    input  logic                     key_valid,
    output logic                     key_ready,
    output logic [47:0]              subkey,
    output logic                     subkey_valid,
    input  logic                     subkey_ready,
    output logic [3:0]               subkey_round,
    output logic [1:0]               subkey_key_idx,
    output logic                     subkey_last
`ifdef KEY_PARITY_CHECK_EN
    ,
    output logic [NUM_KEYS*8-1:0]    parity_err
`endif
);

    state_t                 state, state_nxt;
    logic [3:0]             round;
    logic [1:0]             key_idx;
    logic [64*NUM_KEYS-1:0] key_lat;
    logic [NUM_KEYS-1:0]    mode_lat;
    logic [27:0]            c, d;

    logic                   load, adv, key_done, stream_done;
    logic [1:0]             next_idx;
    logic [64*NUM_KEYS-1:0] key_src;
    logic [NUM_KEYS-1:0]    mode_src;
    logic [63:0]            sel_key;
    logic                   sel_mode, cur_mode;
    logic [55:0]            cd_pc1;
    logic [27:0]            c_load, d_load, c_step, d_step;
    logic [47:0]            pc2_out;

    assign load        = (state == ST_IDLE) && key_valid;
    assign adv         = (state == ST_EMIT) && subkey_ready;
    assign key_done    = (round == 4'd15);
    assign stream_done = key_done && (key_idx == 2'(NUM_KEYS - 1));

    // Key feeding the single PC-1: key 0 of the incoming load, or the next latched key
    always_comb begin
        next_idx = load ? 2'd0 : key_idx + 2'd1;
        key_src  = load ? key_in : key_lat;
        mode_src = load ? key_mode : mode_lat;
        sel_key  = '0;
        sel_mode = 1'b0;
        cur_mode = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (next_idx == 2'(k)) begin
                sel_key  = key_src[64*k +: 64];
                sel_mode = mode_src[k];
            end
            if (key_idx == 2'(k)) begin
                cur_mode = mode_lat[k];
            end
        end
    end

    des_key_permutation1 u_pc1 (
        .key (sel_key),
        .cd  (cd_pc1)
    );

    // Round-0 register value: encrypt pre-applies the first left shift,
    // decrypt starts from the unrotated C0/D0 (which yields K16).
    // Later rounds: encrypt rotates left by SHIFT[r], decrypt rotates right by SHIFT[16-r].
    always_comb begin
        c_load = sel_mode ? cd_pc1[55:28] : rol28(cd_pc1[55:28], SHIFT[0]);
        d_load = sel_mode ? cd_pc1[27:0]  : rol28(cd_pc1[27:0],  SHIFT[0]);
        c_step = cur_mode ? ror28(c, SHIFT[4'd15 - round]) : rol28(c, SHIFT[round + 4'd1]);
        d_step = cur_mode ? ror28(d, SHIFT[4'd15 - round]) : rol28(d, SHIFT[round + 4'd1]);
    end

    des_key_permutation2 u_pc2 (
        .cd     ({c, d}),
        .subkey (pc2_out)
    );

    // Data registers: latched keys and rotating C/D (no reset needed)
    always_ff @(posedge clk) begin
        if (load) begin
            key_lat  <= key_in;
            mode_lat <= key_mode;
        end
        if (load || (adv && key_done && !stream_done)) begin
            c <= c_load;
            d <= d_load;
        end else if (adv && !key_done) begin
            c <= c_step;
            d <= d_step;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (key_valid)            state_nxt = ST_EMIT;
            ST_EMIT: if (adv && stream_done)   state_nxt = ST_IDLE;
            default:                           state_nxt = ST_IDLE;
        endcase
    end

    // Round and key counters; both return to 0 when the stream ends
    always_ff @(posedge clk) begin
        if (rst) begin
            round   <= 4'd0;
            key_idx <= 2'd0;
        end else if (load) begin
            round   <= 4'd0;
            key_idx <= 2'd0;
        end else if (adv) begin
            round <= round + 4'd1;
            if (stream_done)   key_idx <= 2'd0;
            else if (key_done) key_idx <= key_idx + 2'd1;
        end
    end

`ifdef KEY_PARITY_CHECK_EN
    // Odd-parity check of every key byte, captured at the load handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= '0;
        end else if (load) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                for (int b = 0; b < 8; b++) begin
                    parity_err[8*k+b] <= ~(^key_in[64*k + 63 - 8*b -: 8]);
                end
            end
        end
    end
`endif

    // Outputs; subkey is forced to zero while nothing is being offered
    always_comb begin
        key_ready      = (state == ST_IDLE);
        subkey_valid   = (state == ST_EMIT);
        subkey         = subkey_valid ? pc2_out : 48'd0;
        subkey_round   = round;
        subkey_key_idx = key_idx;
        subkey_last    = subkey_valid && stream_done;
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: one NUM_KEYS=1 and one
// NUM_KEYS=3 instance, an independent key-schedule model feeding
// scoreboards, known-answer table, stalls, mid-stream reset and
// (with KEY_PARITY_CHECK_EN) parity flags.
module tb_des_key_schedule;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef logic [15:0][47:0] sks_t;
    typedef struct packed {
        logic [47:0] sk;
        logic [3:0]  rnd;
        logic [1:0]  idx;
        logic        last;
    } exp_t;
    typedef struct packed {
        logic [63:0] key;
        logic        mode;
        logic [3:0]  rnd;
        logic [47:0] sk;
    } kat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // NUM_KEYS = 1 instance
    logic [63:0]  ki1;
    logic         km1, kv1, kr1, sv1, sr1, ls1;
    logic [47:0]  sk1;
    logic [3:0]   rd1;
    logic [1:0]   ix1;
    // NUM_KEYS = 3 instance
    logic [191:0] ki3;
    logic [2:0]   km3;
    logic         kv3, kr3, sv3, sr3, ls3;
    logic [47:0]  sk3;
    logic [3:0]   rd3;
    logic [1:0]   ix3;
`ifdef KEY_PARITY_CHECK_EN
    logic [7:0]   pe1;
    logic [23:0]  pe3;
`endif

    des_key_schedule #(.NUM_KEYS(1)) dut1 (
        .clk(clk), .rst(rst), .key_in(ki1), .key_mode(km1), .key_valid(kv1),
        .key_ready(kr1), .subkey(sk1), .subkey_valid(sv1), .subkey_ready(sr1),
        .subkey_round(rd1), .subkey_key_idx(ix1), .subkey_last(ls1)
`ifdef KEY_PARITY_CHECK_EN
        , .parity_err(pe1)
`endif
    );

    des_key_schedule #(.NUM_KEYS(3)) dut3 (
        .clk(clk), .rst(rst), .key_in(ki3), .key_mode(km3), .key_valid(kv3),
        .key_ready(kr3), .subkey(sk3), .subkey_valid(sv3), .subkey_ready(sr3),
        .subkey_round(rd3), .subkey_key_idx(ix3), .subkey_last(ls3)
`ifdef KEY_PARITY_CHECK_EN
        , .parity_err(pe3)
`endif
    );

    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t sb1[$];
    exp_t sb3[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic fail(input string name);
        total_cnt++;
        $display("FAIL %s: got no completion, required completion within bound", name);
    endtask

    // Textbook schedule: cumulative left shifts from C0/D0, encrypt order K1..K16
    function automatic sks_t model_sched(input logic [63:0] key);
        logic [27:0] c, d;
        logic [55:0] cd;
        sks_t        r;
        int          sh;
        for (int j = 0; j < 28; j++) begin
            c[27-j] = key[64-PC1_T[j]];
            d[27-j] = key[64-PC1_T[28+j]];
        end
        for (int i = 0; i < 16; i++) begin
            sh = (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
            for (int s = 0; s < sh; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) r[i][47-j] = cd[56-PC2_T[j]];
        end
        return r;
    endfunction

    task automatic push_exp(input int which, input logic [63:0] key, input logic mode,
                            input logic [1:0] idx, input logic last_key);
        sks_t s;
        exp_t e;
        s = model_sched(key);
        for (int r = 0; r < 16; r++) begin
            e.sk   = mode ? s[15-r] : s[r];
            e.rnd  = 4'(r);
            e.idx  = idx;
            e.last = last_key && (r == 15);
            if (which == 1) sb1.push_back(e);
            else            sb3.push_back(e);
        end
    endtask

    // Scoreboard / hold monitor, NUM_KEYS = 1
    logic stall1 = 1'b0;
    exp_t prev1;
    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst) begin
            sb1.delete();
            stall1 <= 1'b0;
        end else begin
            if (stall1) chk("hold1", 64'({sk1, rd1, ix1, ls1}), 64'(prev1));
            if (sv1 && sr1) begin
                if (sb1.size() == 0) fail("extra_subkey1");
                else begin
                    e = sb1.pop_front();
                    chk("stream1", 64'({sk1, rd1, ix1, ls1}), 64'(e));
                end
            end
            stall1 <= sv1 && !sr1;
            prev1  <= {sk1, rd1, ix1, ls1};
        end
    end

    // Scoreboard / hold monitor, NUM_KEYS = 3
    logic stall3 = 1'b0;
    exp_t prev3;
    always @(negedge clk) begin : mon3
        exp_t e;
        if (rst) begin
            sb3.delete();
            stall3 <= 1'b0;
        end else begin
            if (stall3) chk("hold3", 64'({sk3, rd3, ix3, ls3}), 64'(prev3));
            if (sv3 && sr3) begin
                if (sb3.size() == 0) fail("extra_subkey3");
                else begin
                    e = sb3.pop_front();
                    chk("stream3", 64'({sk3, rd3, ix3, ls3}), 64'(e));
                end
            end
            stall3 <= sv3 && !sr3;
            prev3  <= {sk3, rd3, ix3, ls3};
        end
    end

    task automatic load1(input logic [63:0] key, input logic mode);
        int n = 0;
        while (!kr1 && n < 300) begin @(posedge clk); #1; n++; end
        if (!kr1) fail("load1_wait");
        ki1 = key; km1 = mode; kv1 = 1'b1;
        push_exp(1, key, mode, 2'd0, 1'b1);
        @(posedge clk); #1;
        kv1 = 1'b0;
    endtask

    task automatic load3(input logic [63:0] k0, input logic [63:0] k1, input logic [63:0] k2,
                         input logic [2:0] modes);
        int n = 0;
        while (!kr3 && n < 300) begin @(posedge clk); #1; n++; end
        if (!kr3) fail("load3_wait");
        ki3 = {k2, k1, k0}; km3 = modes; kv3 = 1'b1;
        push_exp(3, k0, modes[0], 2'd0, 1'b0);
        push_exp(3, k1, modes[1], 2'd1, 1'b0);
        push_exp(3, k2, modes[2], 2'd2, 1'b1);
        @(posedge clk); #1;
        kv3 = 1'b0;
    endtask

    task automatic wait_idle(input int which);
        logic done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            done = (which == 1) ? kr1 : kr3;
        end
        if (!done) fail((which == 1) ? "idle1_timeout" : "idle3_timeout");
    endtask

    localparam logic [63:0] KA = 64'h133457799BBCDFF1;
    localparam logic [63:0] KB = 64'h0E329232EA6D0D73;
    localparam logic [63:0] KC = 64'hA1B2C3D4E5F60718;

    initial begin
        kat_t kat [4];
        logic found;
        kat[0] = '{KA, 1'b0, 4'd0,  48'h1B02EFFC7072};
        kat[1] = '{KA, 1'b0, 4'd15, 48'hCB3D8B0E17F5};
        kat[2] = '{KA, 1'b1, 4'd0,  48'hCB3D8B0E17F5};
        kat[3] = '{KA, 1'b1, 4'd15, 48'h1B02EFFC7072};

        rst = 1'b1;
        ki1 = '0; km1 = 1'b0; kv1 = 1'b0; sr1 = 1'b1;
        ki3 = '0; km3 = '0;   kv3 = 1'b0; sr3 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_key_ready1", 64'(kr1), 64'd1);
        chk("rst_valid1",     64'(sv1), 64'd0);
        chk("rst_outs1",      64'({sk1, rd1, ix1, ls1}), 64'd0);
        chk("rst_key_ready3", 64'(kr3), 64'd1);
        chk("rst_outs3",      64'({sv3, sk3, rd3, ix3, ls3}), 64'd0);
`ifdef KEY_PARITY_CHECK_EN
        chk("rst_parity", 64'({pe3, pe1}), 64'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        // Known-answer table on the single-key instance, subkey_ready held high
        for (int i = 0; i < 4; i++) begin
            load1(kat[i].key, kat[i].mode);
            found = 1'b0;
            for (int c = 0; c < 40 && !found; c++) begin
                @(negedge clk);
                if (sv1 && rd1 == kat[i].rnd) begin
                    found = 1'b1;
                    chk("kat_subkey", 64'(sk1), 64'(kat[i].sk));
                    chk("kat_cycle", 64'(c), 64'(kat[i].rnd));
                    if (kat[i].rnd == 4'd15) begin
                        chk("kat_last", 64'(ls1), 64'd1);
                        @(negedge clk);
                        chk("kat_ready_after", 64'({kr1, sv1}), 64'b10);
                    end
                end
            end
            if (!found) fail("kat_round_timeout");
            wait_idle(1);
        end

        // Three keys enc/dec/enc, no stalls: key index steps every 16 cycles
        load3(KA, KB, KC, 3'b010);
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            if (c % 16 == 0) chk("idx_step", 64'({ix3, rd3}), 64'({2'(c / 16), 4'd0}));
            if (c == 47)     chk("last3", 64'(ls3), 64'd1);
        end
        @(negedge clk);
        chk("ready3_after", 64'(kr3), 64'd1);

        // Random stalls plus key_valid pulses that must be ignored mid-stream
        load3(KC, KA, KB, 3'b101);
        for (int c = 0; c < 500 && sb3.size() > 0; c++) begin
            sr3 = 1'($urandom_range(0, 1));
            kv3 = (c == 3 || c == 10);
            ki3 = ~ki3;
            @(posedge clk); #1;
        end
        kv3 = 1'b0; sr3 = 1'b1;
        @(negedge clk);
        chk("stall_drained", 64'(sb3.size()), 64'd0);
        chk("stall_idle", 64'(kr3), 64'd1);

        // Reset in the middle of key 1 (round 7)
        load3(KB, KC, KA, 3'b000);
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (sv3 && ix3 == 2'd1 && rd3 == 4'd7) found = 1'b1;
        end
        if (!found) fail("reach_round7");
        rst = 1'b1;
        sb3.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valid", 64'(sv3), 64'd0);
        chk("abort_ready", 64'(kr3), 64'd1);
        chk("abort_outs",  64'({sk3, rd3, ix3, ls3}), 64'd0);
        load3(KA, KB, KC, 3'b010);
        @(negedge clk);
        chk("restart_first", 64'({sv3, ix3, rd3}), 64'({1'b1, 2'd0, 4'd0}));
        wait_idle(3);

`ifdef KEY_PARITY_CHECK_EN
        load1(KA, 1'b0);
        @(negedge clk);
        chk("parity_good", 64'(pe1), 64'd0);
        wait_idle(1);
        load1(64'h133457799BBCDFF0, 1'b0);
        @(negedge clk);
        chk("parity_byte7", 64'(pe1), 64'h80);
        chk("parity_still_emits", 64'(sv1), 64'd1);
        wait_idle(1);
`endif

        wait_idle(1);
        wait_idle(3);
        chk("sb1_empty", 64'(sb1.size()), 64'd0);
        chk("sb3_empty", 64'(sb3.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Sequential DES key-schedule generator. It accepts NUM_KEYS 64-bit DES keys in one handshake, applies PC-1, and emits the 48-bit round subkeys one per accepted transfer. Subkeys come out in encrypt or decrypt order per key, so a 3DES EDE datapath can consume K1-enc, K2-dec and K3-enc as a single stream. It sits between key load and the DES round pipeline.

## Interface
- NUM_KEYS, default 3: keys per load, 1 (DES) or 3 (3DES); other values are illegal.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- key_in  in  64*NUM_KEYS  keys in DES bit order [0:63] each; key k occupies bits [64k +: 64], so key 0 is used first.
- key_mode  in  NUM_KEYS  per-key mode: 0 = encrypt order, 1 = decrypt order.
- key_valid  in  1  key_in and key_mode are valid.
- key_ready  out  1  block is idle and accepts a load.
- subkey  out  48  current round subkey, DES bit order [0:47].
- subkey_valid  out  1  subkey is valid.
- subkey_ready  in  1  consumer accepts the subkey.
- subkey_round  out  4  round index 0..15 of the current subkey.
- subkey_key_idx  out  2  index of the key the current subkey belongs to.
- subkey_last  out  1  final subkey of the final key.
- parity_err  out  NUM_KEYS*8  per-byte odd-parity failure flags; present only with the macro.

## Operation
- FSM has two states: IDLE and EMIT. Reset enters IDLE.
- IDLE:
  - key_ready=1.
  - On key_valid: latch key_in and key_mode, load C/D from PC-1 of key 0, set key_idx=0 and round=0, go to EMIT.
- EMIT:
  - subkey_valid=1 and subkey = PC-2(C,D).
  - On subkey_ready: advance round. If round was 15 and key_idx < NUM_KEYS-1, reload C/D from PC-1 of the next key and clear round. If that was the last subkey of the last key, go to IDLE.
- Encrypt rotation: before the subkey of round r is formed, C and D each rotate left by SHIFT[r]. SHIFT = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Decrypt rotation: round 0 uses unrotated C0/D0, giving K16. Before round r≥1, C and D each rotate right by SHIFT[16-r]. The output sequence is K16..K1.
- Implementation choice: register pre-rotated C/D so the output is PC-2 of the registers directly. The total rotation over 16 rounds is 28, so C/D return to their loaded value.
- Backpressure: subkey, subkey_round, subkey_key_idx and subkey_last hold stable while subkey_valid && !subkey_ready.
- key_valid is ignored outside IDLE; key_ready=0 in EMIT.
- rst mid-stream aborts at once: return to IDLE and discard the latched keys.

## Timing
- Reset values:
  - key_ready=1.
  - subkey_valid=0.
  - subkey=0, subkey_round=0, subkey_key_idx=0, subkey_last=0.
  - parity_err=0.
- Latency: first subkey_valid is 1 cycle after the key handshake.
- Throughput: one subkey per cycle while subkey_ready is held high. The full stream takes 16*NUM_KEYS cycles.
- key_ready returns high the cycle after the last handshake. This gives one bubble between streams; back-to-back overlap is not supported.
- subkey_last = (key_idx==NUM_KEYS-1) && (round==15).

## Configuration
- KEY_PARITY_CHECK_EN defined:
  - On the key handshake, each key byte is checked for odd parity (the LSB of each byte is the parity bit).
  - The parity_err port exists and is registered one cycle after the handshake, then held until the next load or reset.
  - Subkeys are emitted regardless of parity.
- Macro undefined: the parity_err port and its logic are absent.

## Structure
- Package des_pkg holds:
  - the SHIFT table as a localparam array;
  - the state enum;
  - a PC-2 index constant array.
- PC-1 reuses the existing des_key_permutation1 block, one instance on the selected key.
- Sub-module des_key_permutation2 implements the combinational 56→48 PC-2.

## Test plan
- Encrypt, NUM_KEYS=1, key 133457799BBCDFF1, subkey_ready=1 -> round 0 subkey 1B02EFFC7072, round 15 subkey CB3D8B0E17F5 with subkey_last=1, then key_ready=1 the next cycle.
- Decrypt, same key -> round 0 gives CB3D8B0E17F5, round 15 gives 1B02EFFC7072; the middle rounds are the encrypt sequence reversed.
- NUM_KEYS=3, modes {enc,dec,enc}, keys k0/k1/k2 -> 48 subkeys; subkey_key_idx steps 0→1→2 at round-0 boundaries; key 1's stream equals its standalone decrypt run.
- Random subkey_ready stalls -> outputs stay stable during stalls and no subkey is lost or duplicated; key_valid pulses during EMIT are ignored.
- rst asserted at round 7 of key 1 -> next cycle subkey_valid=0 and key_ready=1; a new load restarts from key 0, round 0.
- KEY_PARITY_CHECK_EN: key 133457799BBCDFF1 -> parity_err=0. Key 133457799BBCDFF0 -> only the flag for byte 7 is set, and subkeys are still emitted.
